ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared single-port RAM. It accepts read/write commands over valid/ready handshakes and drives the RAM command bus from registers. It routes each RAM read response (data_out qualified by en_out) back to the requester that issued the read. It sits between the two client masters and the ram instance; the RAM has one port, so only one access can be issued per cycle.

---
 rtl/ram_arbiter_pkg.sv | 18 +
 rtl/ram_arbiter_rr_arbiter2.sv | 20 ++
 rtl/ram_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants and state encoding for the RAM arbiter and its
// round-robin grant helper.
package ram_arbiter_pkg;

   localparam int unsigned AddrWidth = 8;
   localparam int unsigned DataWidth = 8;
   localparam int unsigned DataDepth = 256;

   localparam logic Req0 = 1'b0;
   localparam logic Req1 = 1'b1;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRdIssue = 2'd1,
      StRdWait  = 2'd2
   } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie, the requester that did not win last
// time is granted. Purely combinational so it can front any shared resource.
import ram_arbiter_pkg::*;

module rr_arbiter2 (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic last_grant_i,
   output logic gnt0_o,
   output logic gnt1_o,
   output logic gnt_idx_o
);

   always_comb begin
      gnt0_o    = valid0_i & (~valid1_i | (last_grant_i == Req1));
      gnt1_o    = valid1_i & (~valid0_i | (last_grant_i == Req0));
      gnt_idx_o = gnt1_o;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sequencer for a single-port RAM shared by two requesters.
// Commands are registered onto the RAM bus; read data is routed to the issuer.
import ram_arbiter_pkg::*;

module ram_arbiter #(
   parameter int unsigned ADDR_WIDTH = AddrWidth,
   parameter int unsigned DATA_WIDTH = DataWidth
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_wr_rd,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_data,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_wr_rd,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_data,
   output logic                  ram_en,
   output logic                  ram_wr_rd,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   input  logic                  ram_en_out,
   output logic                  busy
);

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_grant_q, last_grant_d;
   logic                  ram_en_q, ram_en_d;
   logic                  ram_wr_rd_q, ram_wr_rd_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;

   logic                  accept_ok;
   logic                  gnt0, gnt1, gnt_idx;
   logic                  hs;
   logic                  sel_wr_rd;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // The RAM port is occupied by the read being issued, so no accept then.
   assign accept_ok = (state_q != StRdIssue);

   rr_arbiter2 u_rr_arbiter2 (
      .valid0_i     (req0_valid),
      .valid1_i     (req1_valid),
      .last_grant_i (last_grant_q),
      .gnt0_o       (gnt0),
      .gnt1_o       (gnt1),
      .gnt_idx_o    (gnt_idx)
   );

   always_comb begin
      req0_ready = gnt0 & accept_ok;
      req1_ready = gnt1 & accept_ok;
      hs         = (req0_valid & req0_ready) | (req1_valid & req1_ready);
      sel_wr_rd  = gnt_idx ? req1_wr_rd : req0_wr_rd;
      sel_addr   = gnt_idx ? req1_addr  : req0_addr;
      sel_wdata  = gnt_idx ? req1_wdata : req0_wdata;
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      last_grant_d  = last_grant_q;
      ram_en_d      = hs;
      ram_wr_rd_d   = ram_wr_rd_q;
      ram_addr_d    = ram_addr_q;
      ram_data_in_d = ram_data_in_q;

      if (hs) begin
         last_grant_d  = gnt_idx;
         ram_wr_rd_d   = sel_wr_rd;
         ram_addr_d    = sel_addr;
         ram_data_in_d = sel_wdata;
         if (!sel_wr_rd) begin
            owner_d = gnt_idx;
         end
      end

      unique case (state_q)
         StIdle:    state_d = (hs && !sel_wr_rd) ? StRdIssue : StIdle;
         StRdIssue: state_d = StRdWait;
         StRdWait:  state_d = (hs && !sel_wr_rd) ? StRdIssue : StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         owner_q       <= Req0;
         last_grant_q  <= Req1;
         ram_en_q      <= 1'b0;
         ram_wr_rd_q   <= 1'b0;
         ram_addr_q    <= '0;
         ram_data_in_q <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_grant_q  <= last_grant_d;
         ram_en_q      <= ram_en_d;
         ram_wr_rd_q   <= ram_wr_rd_d;
         ram_addr_q    <= ram_addr_d;
         ram_data_in_q <= ram_data_in_d;
      end
   end

   // owner_q only moves at the edge, so a response and a new accept can
   // share the RD_WAIT cycle without misrouting.
   always_comb begin
      rsp0_valid  = ram_en_out & (state_q == StRdWait) & (owner_q == Req0);
      rsp1_valid  = ram_en_out & (state_q == StRdWait) & (owner_q == Req1);
      rsp0_data   = ram_data_out;
      rsp1_data   = ram_data_out;
      ram_en      = ram_en_q;
      ram_wr_rd   = ram_wr_rd_q;
      ram_addr    = ram_addr_q;
      ram_data_in = ram_data_in_q;
      busy        = (state_q != StIdle);
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus randomized bench for ram_arbiter with a behavioural RAM and a
// transaction-level reference model (shadow memory and accept timeline).
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0_valid, req0_ready, req0_wr_rd, rsp0_valid;
   logic [7:0] req0_addr, req0_wdata, rsp0_data;
   logic       req1_valid, req1_ready, req1_wr_rd, rsp1_valid;
   logic [7:0] req1_addr, req1_wdata, rsp1_data;
   logic       ram_en, ram_wr_rd, ram_en_out, busy;
   logic [7:0] ram_addr, ram_data_in, ram_data_out;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_wr_rd   (req0_wr_rd),
      .req0_addr    (req0_addr),
      .req0_wdata   (req0_wdata),
      .rsp0_valid   (rsp0_valid),
      .rsp0_data    (rsp0_data),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_wr_rd   (req1_wr_rd),
      .req1_addr    (req1_addr),
      .req1_wdata   (req1_wdata),
      .rsp1_valid   (rsp1_valid),
      .rsp1_data    (rsp1_data),
      .ram_en       (ram_en),
      .ram_wr_rd    (ram_wr_rd),
      .ram_addr     (ram_addr),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out),
      .ram_en_out   (ram_en_out),
      .busy         (busy)
   );

   // Behavioural single-port RAM: write at the edge, read data one cycle later.
   logic [7:0] mem [256];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_en_out   <= 1'b0;
         ram_data_out <= '0;
      end else begin
         ram_en_out <= 1'b0;
         if (ram_en) begin
            if (ram_wr_rd) begin
               mem[ram_addr] <= ram_data_in;
            end else begin
               ram_data_out <= mem[ram_addr];
               ram_en_out   <= 1'b1;
            end
         end
      end
   end

   // Reference model: one record per accepted command, aged one stage per edge.
   typedef struct packed {
      logic       v;
      logic       wr;
      logic       who;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } acc_t;

   logic [7:0] shadow [256];
   acc_t       s1, s2;
   logic       m_can_acc;
   logic       m_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_can_acc = 1'b1;
      m_last    = 1'b1;
      s1        = '0;
      s2        = '0;
   endtask

   task automatic set_req(input int idx, input logic v, input logic wr,
                          input logic [7:0] addr, input logic [7:0] data);
      if (idx == 0) begin
         req0_valid = v; req0_wr_rd = wr; req0_addr = addr; req0_wdata = data;
      end else begin
         req1_valid = v; req1_wr_rd = wr; req1_addr = addr; req1_wdata = data;
      end
   endtask

   // One clock cycle: check everything at the falling edge, advance the model
   // at the rising edge, return which requester (if any) handshook.
   task automatic step(output logic hs0, output logic hs1);
      logic eg0, eg1;
      acc_t a;
      @(negedge clk);
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (m_can_acc) begin
         if (req0_valid && req1_valid) begin
            if (m_last) eg0 = 1'b1;
            else        eg1 = 1'b1;
         end else if (req0_valid) begin
            eg0 = 1'b1;
         end else if (req1_valid) begin
            eg1 = 1'b1;
         end
      end
      chk("req0_ready", {31'b0, req0_ready}, {31'b0, eg0});
      chk("req1_ready", {31'b0, req1_ready}, {31'b0, eg1});
      chk("ram_en", {31'b0, ram_en}, {31'b0, s1.v});
      if (s1.v) begin
         chk("ram_wr_rd", {31'b0, ram_wr_rd}, {31'b0, s1.wr});
         chk("ram_addr", {24'b0, ram_addr}, {24'b0, s1.addr});
         if (s1.wr) chk("ram_data_in", {24'b0, ram_data_in}, {24'b0, s1.wdata});
      end
      chk("busy", {31'b0, busy}, {31'b0, (s1.v & ~s1.wr) | (s2.v & ~s2.wr)});
      chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, s2.v & ~s2.wr & ~s2.who});
      chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, s2.v & ~s2.wr & s2.who});
      if (s2.v && !s2.wr && !s2.who) chk("rsp0_data", {24'b0, rsp0_data}, {24'b0, s2.rdata});
      if (s2.v && !s2.wr && s2.who)  chk("rsp1_data", {24'b0, rsp1_data}, {24'b0, s2.rdata});
      @(posedge clk);
      a = '0;
      if (eg0 || eg1) begin
         a.v     = 1'b1;
         a.who   = eg1;
         a.wr    = eg1 ? req1_wr_rd : req0_wr_rd;
         a.addr  = eg1 ? req1_addr  : req0_addr;
         a.wdata = eg1 ? req1_wdata : req0_wdata;
         a.rdata = shadow[a.addr];
         if (a.wr) shadow[a.addr] = a.wdata;
         m_last = eg1;
      end
      s2        = s1;
      s1        = a;
      m_can_acc = !(a.v && !a.wr);
      hs0       = eg0;
      hs1       = eg1;
      #1;
   endtask

   task automatic idle_steps(input int n);
      logic h0, h1;
      for (int i = 0; i < n; i++) step(h0, h1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
         chk("rst_busy", {31'b0, busy}, 32'd0);
         chk("rst_ram_addr", {24'b0, ram_addr}, 32'd0);
         chk("rst_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
         chk("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      logic h0, h1;
      logic pend0, pend1;
      model_reset();
      do_reset();
      idle_steps(2);

      // Single write then read of 0x05.
      set_req(0, 1'b1, 1'b1, 8'h05, 8'hA5);
      step(h0, h1);
      chk("wr05_hs", {31'b0, h0}, 32'd1);
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      idle_steps(2);
      chk("mem05", {24'b0, mem[5]}, 32'hA5);
      set_req(0, 1'b1, 1'b0, 8'h05, 8'h00);
      step(h0, h1);
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      idle_steps(3);

      // Back-to-back writes from requester 1, then readback.
      for (int i = 0; i < 4; i++) begin
         set_req(1, 1'b1, 1'b1, 8'h10 + 8'(i), 8'hC0 + 8'(i));
         step(h0, h1);
         chk("b2b_hs", {31'b0, h1}, 32'd1);
      end
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      idle_steps(1);
      for (int i = 0; i < 4; i++) begin
         set_req(1, 1'b1, 1'b0, 8'h10 + 8'(i), 8'h00);
         step(h0, h1);
         set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
         step(h0, h1);
      end
      idle_steps(2);

      // Preload 0x01/0x02, then continuous contention for reads.
      set_req(1, 1'b1, 1'b1, 8'h01, 8'h11);
      step(h0, h1);
      set_req(1, 1'b1, 1'b1, 8'h02, 8'h22);
      step(h0, h1);
      set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
      set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
      for (int i = 0; i < 8; i++) begin
         step(h0, h1);
         if (i % 2 == 0) begin
            chk("rr_accept", {31'b0, h0 | h1}, 32'd1);
            chk("rr_grant1", {31'b0, h1}, (i / 2) % 2);
         end else begin
            chk("rr_gap", {31'b0, h0 | h1}, 32'd0);
         end
      end
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      idle_steps(3);

      // Response for req0 and accept for req1 in the same RD_WAIT cycle.
      set_req(0, 1'b1, 1'b0, 8'h05, 8'h00);
      step(h0, h1);
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
      step(h0, h1);
      chk("ovl_blocked", {31'b0, h1}, 32'd0);
      step(h0, h1);
      chk("ovl_accept", {31'b0, h1}, 32'd1);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      idle_steps(3);

      // Random traffic over a preloaded window.
      for (int i = 0; i < 8; i++) begin
         set_req(0, 1'b1, 1'b1, 8'h20 + 8'(i), 8'($urandom));
         step(h0, h1);
      end
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      pend0 = 1'b0;
      pend1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pend0 && $urandom_range(1, 0) == 1) begin
            set_req(0, 1'b1, 1'($urandom), 8'h20 + 8'($urandom_range(7, 0)), 8'($urandom));
            pend0 = 1'b1;
         end
         if (!pend1 && $urandom_range(1, 0) == 1) begin
            set_req(1, 1'b1, 1'($urandom), 8'h20 + 8'($urandom_range(7, 0)), 8'($urandom));
            pend1 = 1'b1;
         end
         step(h0, h1);
         if (h0) begin
            pend0 = 1'b0;
            set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
         end
         if (h1) begin
            pend1 = 1'b0;
            set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
         end
      end
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      idle_steps(3);

      // Reset while a read is on the RAM bus.
      set_req(0, 1'b1, 1'b0, 8'h20, 8'h00);
      step(h0, h1);
      chk("mid_hs", {31'b0, h0}, 32'd1);
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_ram_en", {31'b0, ram_en}, 32'd0);
      chk("mid_busy", {31'b0, busy}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_no_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
         chk("mid_ram_en_hold", {31'b0, ram_en}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      set_req(0, 1'b1, 1'b0, 8'h21, 8'h00);
      set_req(1, 1'b1, 1'b0, 8'h22, 8'h00);
      step(h0, h1);
      chk("post_rst_tie", {30'b0, h1, h0}, 32'd1);
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      idle_steps(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
